dso100_usb_otg_power_ctrl: RTL and testbench

- PL-side sequencer for the USB OTG PHY reset line and VBUS power switch.
- Turns a PS EMIO reset request into a timed, minimum-width active-low PHY reset followed by a recovery hold-off.
- Filters the active-low VBUS overcurrent flag and cuts VBUS on a confirmed fault, with timed auto-retry.
- Reports fault status back to the PS; sits between the PS7 EMIO/USB indication signals and the board pins.

---
 rtl/dso100_usb_pkg.sv | 17 +
 rtl/dso100_sync2.sv | 26 ++
 rtl/dso100_usb_otg_power_ctrl.sv | 142 ++++++++++++++
 tb/tb_dso100_usb_otg_power_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dso100_usb_pkg.sv
// Shared types and helpers for the USB OTG PHY reset / VBUS power sequencer.
package dso100_usb_pkg;

    localparam int unsigned FAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        StRstAssert  = 2'd0,
        StRstRecover = 2'd1,
        StRun        = 2'd2,
        StFaultOff   = 2'd3
    } state_e;

    function automatic logic [FAULT_CNT_W-1:0] sat_inc(input logic [FAULT_CNT_W-1:0] v);
        return (v == '1) ? v : v + FAULT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dso100_sync2.sv
// Two-flop synchroniser for a single asynchronous level, with a selectable reset value.
module dso100_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dso100_usb_otg_power_ctrl.sv
// Sequences the USB OTG PHY reset pulse and VBUS switch, with overcurrent filtering,
// timed fault retry and a saturating fault counter reported to the PS.
module dso100_usb_otg_power_ctrl
    import dso100_usb_pkg::*;
#(
    parameter int unsigned CNT_W                 = 24,
    parameter int unsigned RESET_PULSE_CYCLES    = 100000,
    parameter int unsigned RESET_RECOVERY_CYCLES = 10000,
    parameter int unsigned OC_FILTER_CYCLES      = 1000,
    parameter int unsigned OC_RETRY_CYCLES       = 10000000
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   reset_req,
    input  logic                   otg_vbusoc_n,
    input  logic                   fault_clr,
    output logic                   otg_resetn,
    output logic                   vbus_en,
    output logic                   phy_ready,
    output logic                   pwrfault,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    localparam int unsigned FILT_W = $clog2(OC_FILTER_CYCLES + 1);

    localparam logic [CNT_W-1:0]  PulseLoad   = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RecoverLoad = CNT_W'(RESET_RECOVERY_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RetryLoad   = CNT_W'(OC_RETRY_CYCLES - 1);
    localparam logic [FILT_W-1:0] FiltLast    = FILT_W'(OC_FILTER_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FILT_W-1:0]      filt_q, filt_d;
    logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic                   reset_req_q;
    logic                   otg_resetn_q, vbus_en_q, phy_ready_q, pwrfault_q;

    logic vbusoc_n_sync;
    logic oc;
    logic req_edge;

    // Reset value 1 means "no overcurrent" until real samples arrive.
    dso100_sync2 #(
        .RESET_VAL (1'b1)
    ) u_oc_sync (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .d_i    (otg_vbusoc_n),
        .q_o    (vbusoc_n_sync)
    );

    assign oc       = ~vbusoc_n_sync;
    assign req_edge = reset_req & ~reset_req_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        filt_d      = '0;
        fault_cnt_d = fault_cnt_q;

        if (req_edge) begin
            state_d = StRstAssert;
            cnt_d   = PulseLoad;
        end else begin
            unique case (state_q)
                StRstAssert: begin
                    if (cnt_q == '0) begin
                        state_d = StRstRecover;
                        cnt_d   = RecoverLoad;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StRstRecover: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StRun: begin
                    if (oc) begin
                        if (filt_q == FiltLast) begin
                            state_d     = StFaultOff;
                            cnt_d       = RetryLoad;
                            fault_cnt_d = sat_inc(fault_cnt_q);
                        end else begin
                            filt_d = filt_q + FILT_W'(1);
                        end
                    end
                end
                StFaultOff: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StRstAssert;
                    cnt_d   = PulseLoad;
                end
            endcase
        end

        if (fault_clr) begin
            fault_cnt_d = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= StRstAssert;
            cnt_q        <= PulseLoad;
            filt_q       <= '0;
            fault_cnt_q  <= '0;
            reset_req_q  <= 1'b0;
            otg_resetn_q <= 1'b0;
            vbus_en_q    <= 1'b0;
            phy_ready_q  <= 1'b0;
            pwrfault_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            filt_q       <= filt_d;
            fault_cnt_q  <= fault_cnt_d;
            reset_req_q  <= reset_req;
            // Outputs decode the next state so they move on the same edge as the FSM.
            otg_resetn_q <= (state_d != StRstAssert);
            vbus_en_q    <= (state_d == StRun);
            phy_ready_q  <= (state_d == StRun);
            pwrfault_q   <= (state_d == StFaultOff);
        end
    end

    assign otg_resetn = otg_resetn_q;
    assign vbus_en    = vbus_en_q;
    assign phy_ready  = phy_ready_q;
    assign pwrfault   = pwrfault_q;
    assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_dso100_usb_otg_power_ctrl.sv
// Scoreboard bench: a timer/streak reference model predicts outputs per cycle, a monitor compares.
module tb_dso100_usb_otg_power_ctrl;

    localparam int PULSE  = 10;
    localparam int RECOV  = 5;
    localparam int FILT   = 4;
    localparam int RETRY  = 20;

    localparam int M_RST  = 0;
    localparam int M_REC  = 1;
    localparam int M_RUN  = 2;
    localparam int M_FLT  = 3;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       reset_req = 1'b0;
    logic       otg_vbusoc_n = 1'b1;
    logic       fault_clr = 1'b0;
    logic       otg_resetn, vbus_en, phy_ready, pwrfault;
    logic [7:0] fault_cnt;

    dso100_usb_otg_power_ctrl #(
        .CNT_W                 (8),
        .RESET_PULSE_CYCLES    (PULSE),
        .RESET_RECOVERY_CYCLES (RECOV),
        .OC_FILTER_CYCLES      (FILT),
        .OC_RETRY_CYCLES       (RETRY)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .reset_req    (reset_req),
        .otg_vbusoc_n (otg_vbusoc_n),
        .fault_clr    (fault_clr),
        .otg_resetn   (otg_resetn),
        .vbus_en      (vbus_en),
        .phy_ready    (phy_ready),
        .pwrfault     (pwrfault),
        .fault_cnt    (fault_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic       rn;
        logic       ve;
        logic       pr;
        logic       pf;
        logic [7:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;
    string phase = "init";

    // Reference model: phase + remaining cycles, consecutive-overcurrent streak, fault tally.
    int mode = M_RST;
    int left = PULSE;
    int streak = 0;
    int faults = 0;
    bit prev_req = 1'b0;
    bit syn_q[$] = '{1'b1, 1'b1};

    task automatic model_step(input bit rstn, input bit req, input bit ocn, input bit clr);
        bit s;
        bit oc;
        bit rise;
        exp_t e;
        if (!rstn) begin
            mode = M_RST; left = PULSE; streak = 0; faults = 0; prev_req = 1'b0;
            syn_q = '{1'b1, 1'b1};
        end else begin
            s = syn_q.pop_front();
            syn_q.push_back(ocn);
            oc = !s;
            rise = req && !prev_req;
            prev_req = req;
            if (rise) begin
                mode = M_RST; left = PULSE; streak = 0;
            end else begin
                case (mode)
                    M_RST: begin
                        left--;
                        if (left == 0) begin mode = M_REC; left = RECOV; end
                    end
                    M_REC: begin
                        left--;
                        if (left == 0) mode = M_RUN;
                    end
                    M_RUN: begin
                        streak = oc ? streak + 1 : 0;
                        if (streak == FILT) begin
                            mode = M_FLT; left = RETRY; streak = 0;
                            if (faults < 255) faults++;
                        end
                    end
                    default: begin
                        left--;
                        if (left == 0) begin mode = M_RUN; streak = 0; end
                    end
                endcase
            end
            if (clr) faults = 0;
        end
        e.rn = (mode != M_RST);
        e.ve = (mode == M_RUN);
        e.pr = (mode == M_RUN);
        e.pf = (mode == M_FLT);
        e.fc = 8'(faults);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rstn, input bit req, input bit ocn, input bit clr);
        @(negedge aclk);
        aresetn = rstn; reset_req = req; otg_vbusoc_n = ocn; fault_clr = clr;
        model_step(rstn, req, ocn, clr);
    endtask

    function automatic bit will_trip(input bit req);
        return mode == M_RUN && !syn_q[0] && streak == FILT - 1 && !(req && !prev_req);
    endfunction

    // Monitor: the DUT presents a fresh output set after every edge.
    always @(posedge aclk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({otg_resetn, vbus_en, phy_ready, pwrfault, fault_cnt} !== e) begin
                fails++;
                $display("FAIL %s t=%0t: got rn=%b ve=%b pr=%b pf=%b fc=%0d, want rn=%b ve=%b pr=%b pf=%b fc=%0d",
                         phase, $time, otg_resetn, vbus_en, phy_ready, pwrfault, fault_cnt,
                         e.rn, e.ve, e.pr, e.pf, e.fc);
            end
        end
    end

    initial begin
        bit lvl;
        bit req;
        int n;

        phase = "power_on";
        repeat (3) step(0, 0, 1, 0);
        repeat (25) step(1, 0, 1, 0);

        phase = "glitch";
        repeat (3) step(1, 0, 0, 0);
        repeat (6) step(1, 0, 1, 0);
        repeat (8) step(1, 0, 0, 0);

        phase = "retry";
        repeat (40) step(1, 0, 0, 0);
        while (mode != M_FLT) step(1, 0, 0, 0);
        repeat (5) step(1, 0, 1, 0);
        repeat (40) step(1, 0, 1, 0);

        phase = "req_in_fault";
        n = 0;
        while (mode != M_FLT && n < 50) begin step(1, 0, 0, 0); n++; end
        repeat (3) step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        repeat (5) step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        repeat (25) step(1, 0, 1, 0);

        phase = "saturate";
        n = 0;
        while (faults < 255 && n < 9000) begin step(1, 0, 0, 0); n++; end
        repeat (100) step(1, 0, 0, 0);
        phase = "clear_on_trip";
        n = 0;
        while (!will_trip(1'b0) && n < 100) begin step(1, 0, 0, 0); n++; end
        step(1, 0, 0, 1);
        repeat (60) step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        repeat (10) step(1, 0, 1, 0);

        phase = "random";
        lvl = 1'b1; req = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) lvl = ~lvl;
            if ($urandom_range(59) == 0) req = ~req;
            if ($urandom_range(499) == 0) begin
                step(0, req, lvl, 1'b0);
            end else begin
                step(1, req, lvl, ($urandom_range(49) == 0));
            end
        end

        phase = "reset_mid_run";
        repeat (30) step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        repeat (20) step(1, 1, 1, 0);
        repeat (2) step(0, 1, 1, 0);
        repeat (40) step(1, 1, 1, 0);

        @(negedge aclk);
        @(negedge aclk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
